// File: rtl/pc_gen.sv
// Program-counter generation: boot-time instruction upload sequencer followed by the
// run-time PC register with branch/JAL/JALR selection and sticky error reporting.
module pc_gen #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic        load_last,
    output logic        load_ready,
    output logic        iwr_en,
    output logic [31:0] iwaddr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        running,
    output logic        misalign_err,
    output logic        range_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StErr} state_e;

    state_e      state_q, state_d;
    logic [29:0] word_cnt_q, word_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic        range_q, range_d;
    logic [31:0] target;
    logic        last_word;
    logic        out_of_range;

    // Priority: jalr > jal > br_taken > sequential; JAL and branch share one adder.
    always_comb begin
        if (jalr) begin
            target = (rs1_val + imm) & ~32'h1;
        end else if (jal || br_taken) begin
            target = pc_q + imm;
        end else begin
            target = pc_q + 32'd4;
        end
    end

    assign last_word    = (word_cnt_q == 30'(MEM_WORDS - 1));
    assign out_of_range = ({2'b00, target[31:2]} >= MEM_WORDS);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        range_d    = range_q;
        unique case (state_q)
            StIdle: begin
                pc_d = RESET_VEC;
                if (load_start) begin
                    state_d    = StLoad;
                    word_cnt_d = '0;
                end
            end
            StLoad: begin
                if (load_valid) begin
                    word_cnt_d = word_cnt_q + 30'd1;
                    if (load_last || last_word) begin
                        state_d = StRun;
                        pc_d    = RESET_VEC;
                    end
                end
            end
            StRun: begin
                if (!stall) begin
                    if (target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = StErr;
                    end else begin
                        // Out-of-range target is still loaded so it is visible for debug.
                        pc_d = target;
                        if (out_of_range) begin
                            range_d = 1'b1;
                            state_d = StErr;
                        end
                    end
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            range_q    <= range_d;
        end
    end

    assign load_ready   = (state_q == StLoad);
    assign iwr_en       = load_valid & load_ready;
    assign iwaddr       = {word_cnt_q, 2'b00};
    assign running      = (state_q == StRun);
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign misalign_err = misalign_q;
    assign range_err    = range_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: expected post-edge state is queued when stimulus is
// applied and compared after the rising edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, load_valid, load_last;
    logic        load_ready, iwr_en;
    logic [31:0] iwaddr;
    logic        stall, br_taken, jal, jalr;
    logic [31:0] imm, rs1_val;
    logic [31:0] pc, pc_plus4;
    logic        running, misalign_err, range_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        running;
        logic        load_ready;
        logic        merr;
        logic        rerr;
    } exp_t;

    exp_t sb_q[$];

    pc_gen #(
        .RESET_VEC(32'h0000_0000),
        .MEM_WORDS(20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .iwr_en      (iwr_en),
        .iwaddr      (iwaddr),
        .stall       (stall),
        .br_taken    (br_taken),
        .jal         (jal),
        .jalr        (jalr),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .running     (running),
        .misalign_err(misalign_err),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        jal        = 1'b0;
        jalr       = 1'b0;
        imm        = 32'd0;
        rs1_val    = 32'd0;
    endtask

    // Queue the expected post-edge state, clock once, then compare.
    task automatic tick(input string tag, input logic [31:0] e_pc, input logic e_run,
                        input logic e_ldr, input logic e_merr, input logic e_rerr);
        exp_t e;
        e.tag = tag; e.pc = e_pc; e.running = e_run; e.load_ready = e_ldr;
        e.merr = e_merr; e.rerr = e_rerr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".pc"}, pc, e.pc);
        check({e.tag, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        check({e.tag, ".running"}, 32'(running), 32'(e.running));
        check({e.tag, ".load_ready"}, 32'(load_ready), 32'(e.load_ready));
        check({e.tag, ".misalign_err"}, 32'(misalign_err), 32'(e.merr));
        check({e.tag, ".range_err"}, 32'(range_err), 32'(e.rerr));
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    // Upload one word with last flag; checks the combinational write strobe/address.
    task automatic load_word(input string tag, input logic last, input logic [31:0] addr,
                             input logic exit_run);
        load_valid = 1'b1;
        load_last  = last;
        #1;
        check({tag, ".iwr_en"}, 32'(iwr_en), 32'd1);
        check({tag, ".iwaddr"}, iwaddr, addr);
        tick(tag, 32'd0, exit_run, !exit_run, 1'b0, 1'b0);
    endtask

    task automatic run_step(input string tag, input logic s, input logic b, input logic j,
                            input logic jr, input logic [31:0] im, input logic [31:0] rs,
                            input logic [31:0] e_pc, input logic e_run, input logic e_merr,
                            input logic e_rerr);
        stall = s; br_taken = b; jal = j; jalr = jr; imm = im; rs1_val = rs;
        tick(tag, e_pc, e_run, 1'b0, e_merr, e_rerr);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #12;
        check("reset.pc", pc, 32'd0);
        check("reset.running", 32'(running), 32'd0);
        check("reset.load_ready", 32'(load_ready), 32'd0);
        check("reset.iwr_en", 32'(iwr_en), 32'd0);
        check("reset.errs", {30'd0, misalign_err, range_err}, 32'd0);
        rst = 1'b0;
        #4;

        // Idle holds; then a 3-word upload with one gap cycle.
        tick("idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        load_start = 1'b1;
        tick("start", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        load_word("w0", 1'b0, 32'd0, 1'b0);
        #1;
        check("gap.iwr_en", 32'(iwr_en), 32'd0);
        tick("gap", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        load_start = 1'b1;   // ignored in LOAD
        load_word("w1", 1'b0, 32'd4, 1'b0);
        load_word("w2", 1'b1, 32'd8, 1'b1);

        // Sequential run with a two-cycle stall at 8.
        run_step("seq4", 0, 0, 0, 0, 32'd0, 32'd0, 32'd4, 1, 0, 0);
        run_step("seq8", 0, 0, 0, 0, 32'd0, 32'd0, 32'd8, 1, 0, 0);
        run_step("stall1", 1, 1, 1, 1, 32'd16, 32'd0, 32'd8, 1, 0, 0);
        run_step("stall2", 1, 0, 0, 0, 32'd0, 32'd0, 32'd8, 1, 0, 0);
        run_step("seq12", 0, 0, 0, 0, 32'd0, 32'd0, 32'd12, 1, 0, 0);
        run_step("br_m4", 0, 1, 0, 0, -32'sd4, 32'd0, 32'd8, 1, 0, 0);
        run_step("br_m8", 0, 1, 0, 0, -32'sd8, 32'd0, 32'd0, 1, 0, 0);
        run_step("seq4b", 0, 0, 0, 0, 32'd0, 32'd0, 32'd4, 1, 0, 0);
        run_step("seq8b", 0, 0, 0, 0, 32'd0, 32'd0, 32'd8, 1, 0, 0);
        run_step("jal16", 0, 0, 1, 0, 32'd16, 32'd0, 32'd24, 1, 0, 0);
        run_step("jalr", 0, 0, 0, 1, 32'd4, 32'h21, 32'h24, 1, 0, 0);
        run_step("jal_br", 0, 1, 1, 0, -32'sd32, 32'd0, 32'd4, 1, 0, 0);
        run_step("jalr_jal", 0, 1, 1, 1, 32'd0, 32'd8, 32'd8, 1, 0, 0);

        // Full-depth upload without load_last, gaps every fifth word.
        do_reset();
        check("rst2.pc", pc, 32'd0);
        load_start = 1'b1;
        tick("start2", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 2) begin
                #1;
                check("gap2.iwr_en", 32'(iwr_en), 32'd0);
                tick("gap2", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            load_word("full", 1'b0, 32'(i * 4), i == 19);
        end

        // Misaligned JAL target: sticky error, pc unchanged, frozen.
        run_step("jal6", 0, 0, 1, 0, 32'd6, 32'd0, 32'd0, 0, 1, 0);
        run_step("err_hold", 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 1, 0);

        // Asynchronous reset mid-upload.
        do_reset();
        load_start = 1'b1;
        tick("start3", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        load_word("w3a", 1'b0, 32'd0, 1'b0);
        load_valid = 1'b1;
        #1;
        check("pre_rst.iwaddr", iwaddr, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.iwr_en", 32'(iwr_en), 32'd0);
        check("async_rst.load_ready", 32'(load_ready), 32'd0);
        check("async_rst.iwaddr", iwaddr, 32'd0);
        rst = 1'b0;
        clear_inputs();
        tick("post_rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        load_start = 1'b1;
        tick("start4", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        load_word("w4", 1'b1, 32'd0, 1'b1);

        // Out-of-range target: pc is loaded, then frozen.
        run_step("jal200", 0, 0, 1, 0, 32'd200, 32'd0, 32'd200, 0, 0, 1);
        run_step("rerr_hold", 0, 0, 0, 0, 32'd0, 32'd0, 32'd200, 0, 0, 1);

        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
